// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default sizes for the memory arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_LATENCY = 1;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_arbiter_prio.sv
// arb_prio: data-first winner select with a starvation counter that hands priority to fetch
module arb_prio import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic d_valid,
  input  logic grant_ok,
  output logic grant_if,
  output logic grant_d
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  always_comb begin
    grant_d = grant_ok && d_valid && !(if_valid && starve == SW'(STARVE_MAX));
    grant_if = grant_ok && if_valid && !grant_d;
  end
  always_ff @(posedge clk)
    if (!rst || !if_valid || grant_if) starve <= '0;
    else if (grant_d && starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one BRAM port between instruction fetch and data accesses
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  state_t state, state_n;
  owner_t owner, owner_n;
  logic [LW-1:0] lat_cnt, lat_cnt_n;
  logic done, grant_ok, grant_if, grant_d, rd;
  assign done = rst && state == BUSY && lat_cnt == '0;
  assign grant_ok = rst && (state == IDLE || done);
  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk(clk),
    .rst(rst),
    .if_valid(if_valid),
    .d_valid(d_valid),
    .grant_ok(grant_ok),
    .grant_if(grant_if),
    .grant_d(grant_d)
  );
  always_comb begin
    rd = grant_if || (grant_d && d_we == 4'h0);
    if_ready = grant_if;
    d_ready = grant_d;
    stall = if_valid && !grant_if;
    mem_en = grant_if || grant_d;
    mem_we = grant_d ? d_we : 4'h0;
    mem_addr = grant_d ? d_addr : if_addr;
    mem_wdata = d_wdata;
    if_rvalid = done && owner == OWN_IF;
    d_rvalid = done && owner == OWN_D;
    if_rdata = mem_rdata;
    d_rdata = mem_rdata;
    state_n = rd ? BUSY : done ? IDLE : state;
    lat_cnt_n = rd ? LW'(MEM_LATENCY - 1) : (state == BUSY && lat_cnt != '0) ? lat_cnt - LW'(1) : lat_cnt;
    owner_n = rd ? (grant_d ? OWN_D : OWN_IF) : owner;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      owner <= OWN_IF;
    end else begin
      state <= state_n;
      lat_cnt <= lat_cnt_n;
      owner <= owner_n;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed latency/reset sequences and a random run against a timestamp model
module tb_mem_arbiter;
  localparam int STARVE = 4;
  typedef struct {
    logic rst, ifv, dv;
    logic [13:0] ifa, da;
    logic [3:0] we;
    logic ir, dr, iv, dvv, en, st;
    logic [3:0] ewe;
    logic [13:0] ea;
    logic [31:0] ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_v [2], d_v [2], i_rdy [2], d_rdy [2], i_rv [2], d_rv [2], m_en [2], stl [2];
  logic [13:0] i_a [2], d_a [2], m_ad [2];
  logic [3:0] d_we [2], m_we [2];
  logic [31:0] d_wd [2], i_rd [2], d_rd [2], m_wd [2], m_rd [2];
  logic [31:0] mem [2][16384];
  logic [31:0] pipe [2][3];
  logic primed = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t tv [17];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : du
    mem_arbiter #(.MEM_LATENCY(g ? 3 : 1)) dut (
      .clk(clk), .rst(rst),
      .if_valid(i_v[g]), .if_ready(i_rdy[g]), .if_addr(i_a[g]), .if_rvalid(i_rv[g]), .if_rdata(i_rd[g]),
      .d_valid(d_v[g]), .d_ready(d_rdy[g]), .d_addr(d_a[g]), .d_we(d_we[g]), .d_wdata(d_wd[g]),
      .d_rvalid(d_rv[g]), .d_rdata(d_rd[g]),
      .mem_en(m_en[g]), .mem_we(m_we[g]), .mem_addr(m_ad[g]), .mem_wdata(m_wd[g]), .mem_rdata(m_rd[g]),
      .stall(stl[g])
    );
  end
  function automatic logic [31:0] init(input logic [13:0] a);
    return a == 14'h010 ? 32'h00200013 : {8'hA5, 10'h0, a};
  endfunction
  always @(posedge clk)
    if (!primed) begin
      for (int k = 0; k < 2; k++) for (int a = 0; a < 16384; a++) mem[k][a] <= init(14'(a));
      primed <= 1'b1;
    end else for (int k = 0; k < 2; k++) begin
      if (m_en[k] && m_we[k] == 4'h0) pipe[k][0] <= mem[k][m_ad[k]];
      for (int b = 0; b < 4; b++) if (m_en[k] && m_we[k][b]) mem[k][m_ad[k]][8*b +: 8] <= m_wd[k][8*b +: 8];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  assign m_rd[0] = pipe[0][0];
  assign m_rd[1] = pipe[1][2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input int k, input logic r, input logic iv, input logic [13:0] ia,
                     input logic dv, input logic [13:0] da, input logic [3:0] we);
    @(posedge clk);
    #1;
    rst = r;
    i_v[k] = iv;
    i_a[k] = ia;
    d_v[k] = dv;
    d_a[k] = da;
    d_we[k] = we;
    d_wd[k] = 32'hDEADBEEF;
    @(negedge clk);
  endtask
  task automatic rand_run(input int k, input int n);
    int lat, starve, due;
    bit busy, own_d, ge_i, ge_d, dn, el;
    logic [31:0] sh [64];
    logic [31:0] rdv;
    lat = k ? 3 : 1;
    starve = 0;
    due = 0;
    busy = 0;
    own_d = 0;
    ge_i = 1;
    ge_d = 1;
    rdv = 0;
    for (int a = 0; a < 64; a++) sh[a] = init(14'h200 + 14'(a));
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rst = 1;
      if (!i_v[k] || ge_i) begin
        i_v[k] = $urandom_range(0, 2) != 0;
        i_a[k] = 14'h200 + 14'($urandom_range(0, 63));
      end
      if (!d_v[k] || ge_d) begin
        d_v[k] = $urandom_range(0, 2) != 0;
        d_a[k] = 14'h200 + 14'($urandom_range(0, 63));
        d_we[k] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wd[k] = $urandom;
      end
      @(negedge clk);
      dn = busy && c == due;
      el = !busy || dn;
      ge_d = el && d_v[k] && !(i_v[k] && starve >= STARVE);
      ge_i = el && i_v[k] && !ge_d;
      chk("rnd_if_ready", i_rdy[k], ge_i);
      chk("rnd_d_ready", d_rdy[k], ge_d);
      chk("rnd_stall", stl[k], i_v[k] && !ge_i);
      chk("rnd_if_rvalid", i_rv[k], dn && !own_d);
      chk("rnd_d_rvalid", d_rv[k], dn && own_d);
      if (dn) chk("rnd_rdata", own_d ? d_rd[k] : i_rd[k], rdv);
      chk("rnd_mem_en", m_en[k], ge_i || ge_d);
      if (ge_i || ge_d) begin
        chk("rnd_mem_addr", m_ad[k], ge_d ? d_a[k] : i_a[k]);
        chk("rnd_mem_we", m_we[k], ge_d ? d_we[k] : 4'h0);
        if (ge_d && d_we[k] != 4'h0) chk("rnd_mem_wdata", m_wd[k], d_wd[k]);
      end
      if (dn) busy = 0;
      if (ge_i || (ge_d && d_we[k] == 4'h0)) begin
        busy = 1;
        due = c + lat;
        own_d = ge_d;
        rdv = sh[ge_d ? d_a[k][5:0] : i_a[k][5:0]];
      end
      if (ge_d) for (int b = 0; b < 4; b++) if (d_we[k][b]) sh[d_a[k][5:0]][8*b +: 8] = d_wd[k][8*b +: 8];
      starve = (!i_v[k] || ge_i) ? 0 : (ge_d && starve < STARVE) ? starve + 1 : starve;
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      i_v[k] = 0; i_a[k] = 0; d_v[k] = 0; d_a[k] = 0; d_we[k] = 0; d_wd[k] = 0;
    end
    tv[0] = '{0, 1, 1, 14'h010, 14'h020, 4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 14'h000, 32'h0};
    tv[1] = tv[0];
    tv[2] = '{1, 1, 1, 14'h010, 14'h020, 4'h0, 0, 1, 0, 0, 1, 1, 4'h0, 14'h020, 32'h0};
    tv[3] = '{1, 1, 0, 14'h010, 14'h020, 4'h0, 1, 0, 0, 1, 1, 0, 4'h0, 14'h010, init(14'h020)};
    tv[4] = '{1, 0, 0, 14'h010, 14'h000, 4'h0, 0, 0, 1, 0, 0, 0, 4'h0, 14'h000, 32'h00200013};
    tv[5] = '{1, 0, 0, 14'h010, 14'h000, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 14'h000, 32'h0};
    tv[6] = '{1, 1, 0, 14'h010, 14'h000, 4'h0, 1, 0, 0, 0, 1, 0, 4'h0, 14'h010, 32'h0};
    tv[7] = tv[4];
    for (int r = 8; r < 12; r++) tv[r] = '{1, 1, 1, 14'h010, 14'h030, 4'hF, 0, 1, 0, 0, 1, 1, 4'hF, 14'h030, 32'h0};
    tv[12] = '{1, 1, 1, 14'h010, 14'h030, 4'hF, 1, 0, 0, 0, 1, 0, 4'h0, 14'h010, 32'h0};
    tv[13] = '{1, 1, 1, 14'h010, 14'h030, 4'hF, 0, 1, 1, 0, 1, 1, 4'hF, 14'h030, 32'h00200013};
    tv[14] = tv[5];
    tv[15] = '{1, 0, 1, 14'h010, 14'h030, 4'h0, 0, 1, 0, 0, 1, 0, 4'h0, 14'h030, 32'h0};
    tv[16] = '{1, 0, 0, 14'h010, 14'h030, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 14'h000, 32'hDEADBEEF};
    for (int r = 0; r < 17; r++) begin
      cyc(0, tv[r].rst, tv[r].ifv, tv[r].ifa, tv[r].dv, tv[r].da, tv[r].we);
      chk($sformatf("v%0d_if_ready", r), i_rdy[0], tv[r].ir);
      chk($sformatf("v%0d_d_ready", r), d_rdy[0], tv[r].dr);
      chk($sformatf("v%0d_if_rvalid", r), i_rv[0], tv[r].iv);
      chk($sformatf("v%0d_d_rvalid", r), d_rv[0], tv[r].dvv);
      chk($sformatf("v%0d_mem_en", r), m_en[0], tv[r].en);
      chk($sformatf("v%0d_stall", r), stl[0], tv[r].st);
      if (tv[r].en) begin
        chk($sformatf("v%0d_mem_addr", r), m_ad[0], tv[r].ea);
        chk($sformatf("v%0d_mem_we", r), m_we[0], tv[r].ewe);
      end
      if (tv[r].iv) chk($sformatf("v%0d_if_rdata", r), i_rd[0], tv[r].ed);
      if (tv[r].dvv) chk($sformatf("v%0d_d_rdata", r), d_rd[0], tv[r].ed);
    end
    cyc(1, 1, 0, 0, 1, 14'h100, 4'h0);
    chk("lat_acc0_ready", d_rdy[1], 1);
    chk("lat_acc0_en", m_en[1], 1);
    chk("lat_acc0_addr", m_ad[1], 14'h100);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 1, 14'h104, 4'h0);
      chk("lat_wait_ready", d_rdy[1], 0);
      chk("lat_wait_en", m_en[1], 0);
      chk("lat_wait_rvalid", d_rv[1], 0);
    end
    cyc(1, 1, 0, 0, 1, 14'h104, 4'h0);
    chk("lat_rv0", d_rv[1], 1);
    chk("lat_rv0_data", d_rd[1], init(14'h100));
    chk("lat_acc1_ready", d_rdy[1], 1);
    chk("lat_acc1_en", m_en[1], 1);
    chk("lat_acc1_addr", m_ad[1], 14'h104);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 4'h0);
      chk("lat_idle_en", m_en[1], 0);
      chk("lat_idle_rvalid", d_rv[1], 0);
    end
    cyc(1, 1, 0, 0, 0, 0, 4'h0);
    chk("lat_rv1", d_rv[1], 1);
    chk("lat_rv1_data", d_rd[1], init(14'h104));
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 14'h010, 1, 14'h050, 4'hF);
      chk("rst_pre_d_ready", d_rdy[1], 1);
      chk("rst_pre_if_ready", i_rdy[1], 0);
    end
    cyc(1, 1, 1, 14'h010, 1, 14'h040, 4'h0);
    chk("rst_read_acc", d_rdy[1], 1);
    cyc(1, 0, 1, 14'h010, 0, 0, 4'h0);
    chk("rst_in_if_ready", i_rdy[1], 0);
    chk("rst_in_rvalid", d_rv[1], 0);
    chk("rst_in_en", m_en[1], 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 14'h010, 1, 14'h050, 4'hF);
      chk($sformatf("rst_post%0d_d_ready", i), d_rdy[1], i < 4);
      chk($sformatf("rst_post%0d_if_ready", i), i_rdy[1], i == 4);
      chk($sformatf("rst_post%0d_d_rvalid", i), d_rv[1], 0);
      chk($sformatf("rst_post%0d_if_rvalid", i), i_rv[1], 0);
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) cyc(j, 0, 0, 0, 0, 0, 4'h0);
      rand_run(k, 300);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
